// File: rtl/axis_frame_len_adjust.sv
// Byte-wide AXI-Stream frame length normaliser.
// Short frames are zero-padded up to a minimum length. Long frames are cut at a
// maximum length and the rest of the input frame is dropped. One status record is
// produced per input frame.
module axis_frame_len_adjust #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  length_min,
    input  logic [LEN_WIDTH-1:0]  length_max,
    output logic                  status_valid,
    output logic                  status_frame_pad,
    output logic                  status_frame_truncate,
    output logic [LEN_WIDTH-1:0]  status_frame_length,
    output logic [LEN_WIDTH-1:0]  status_orig_length
);

    // StIdle and StXfer behave identically; StIdle only marks "fresh out of reset".
    typedef enum logic [1:0] {StIdle, StXfer, StPad, StDrop} state_e;

    state_e                state_q, state_d;
    logic                  run_q;
    logic [LEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
    logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
    logic [LEN_WIDTH-1:0]  min_q, min_d;
    logic [LEN_WIDTH-1:0]  max_q, max_d;
    logic [USER_WIDTH-1:0] pad_user_q, pad_user_d;

    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

    logic                  st_valid_q, st_valid_d;
    logic                  st_pad_q, st_pad_d;
    logic                  st_trunc_q, st_trunc_d;
    logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
    logic [LEN_WIDTH-1:0]  st_orig_q, st_orig_d;

    logic                  load;
    logic                  first;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  eff_min;
    logic [LEN_WIDTH-1:0]  cur_min;
    logic [LEN_WIDTH-1:0]  cur_max;
    logic [LEN_WIDTH-1:0]  in_n;
    logic [LEN_WIDTH-1:0]  out_n;

    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
        return (&v) ? v : v + LEN_WIDTH'(1);
    endfunction

    // Handshake, config selection and saturating beat counts.
    always_comb begin
        load    = m_axis_tready || !m_tvalid_q;
        first   = ((state_q == StIdle) || (state_q == StXfer)) && (in_cnt_q == '0);
        eff_min = ((length_max != '0) && (length_min > length_max)) ? length_max : length_min;
        // Config is taken live on the first beat and from the latch afterwards.
        cur_min = first ? eff_min : min_q;
        cur_max = first ? length_max : max_q;
        in_n    = sat_inc(in_cnt_q);
        out_n   = sat_inc(out_cnt_q);
        // run_q keeps tready low in reset and until the first edge after release.
        unique case (state_q)
            StIdle, StXfer: s_axis_tready = run_q && load;
            StPad:          s_axis_tready = 1'b0;
            StDrop:         s_axis_tready = run_q;
            default:        s_axis_tready = 1'b0;
        endcase
        accept = s_axis_tvalid && s_axis_tready;
    end

    // Next-state, output register and status record.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        pad_user_d = pad_user_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        st_valid_d = 1'b0;
        st_pad_d   = st_pad_q;
        st_trunc_d = st_trunc_q;
        st_len_d   = st_len_q;
        st_orig_d  = st_orig_q;

        // Output register drains when loadable; a new beat below refills it.
        if (load) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StXfer: begin
                if (accept) begin
                    state_d    = StXfer;
                    min_d      = cur_min;
                    max_d      = cur_max;
                    in_cnt_d   = in_n;
                    out_cnt_d  = out_n;
                    m_tdata_d  = s_axis_tdata;
                    m_tuser_d  = s_axis_tuser;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    if (s_axis_tlast) begin
                        if (in_n >= cur_min) begin
                            m_tlast_d  = 1'b1;
                            st_valid_d = 1'b1;
                            st_pad_d   = 1'b0;
                            st_trunc_d = 1'b0;
                            st_len_d   = out_n;
                            st_orig_d  = in_n;
                            in_cnt_d   = '0;
                            out_cnt_d  = '0;
                        end else begin
                            pad_user_d = s_axis_tuser;
                            state_d    = StPad;
                        end
                    end else if ((cur_max != '0) && (in_n == cur_max)) begin
                        m_tlast_d = 1'b1;
                        state_d   = StDrop;
                    end
                end
            end
            StPad: begin
                if (load) begin
                    m_tdata_d  = '0;
                    m_tuser_d  = pad_user_q;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    out_cnt_d  = out_n;
                    if (out_n >= min_q) begin
                        m_tlast_d  = 1'b1;
                        st_valid_d = 1'b1;
                        st_pad_d   = 1'b1;
                        st_trunc_d = 1'b0;
                        st_len_d   = out_n;
                        st_orig_d  = in_cnt_q;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        state_d    = StXfer;
                    end
                end
            end
            StDrop: begin
                if (accept) begin
                    in_cnt_d = in_n;
                    if (s_axis_tlast) begin
                        st_valid_d = 1'b1;
                        st_pad_d   = 1'b0;
                        st_trunc_d = 1'b1;
                        st_len_d   = out_cnt_q;
                        st_orig_d  = in_n;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        state_d    = StXfer;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters, output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            min_q      <= '0;
            max_q      <= '0;
            pad_user_q <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
            st_valid_q <= 1'b0;
            st_pad_q   <= 1'b0;
            st_trunc_q <= 1'b0;
            st_len_q   <= '0;
            st_orig_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            pad_user_q <= pad_user_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            st_valid_q <= st_valid_d;
            st_pad_q   <= st_pad_d;
            st_trunc_q <= st_trunc_d;
            st_len_q   <= st_len_d;
            st_orig_q  <= st_orig_d;
        end
    end

    assign m_axis_tdata          = m_tdata_q;
    assign m_axis_tvalid         = m_tvalid_q;
    assign m_axis_tlast          = m_tlast_q;
    assign m_axis_tuser          = m_tuser_q;
    assign status_valid          = st_valid_q;
    assign status_frame_pad      = st_pad_q;
    assign status_frame_truncate = st_trunc_q;
    assign status_frame_length   = st_len_q;
    assign status_orig_length    = st_orig_q;

endmodule

// File: tb/tb_axis_frame_len_adjust.sv
// Bench for axis_frame_len_adjust: frame-level reference model plus scoreboard.
module tb_axis_frame_len_adjust;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic [15:0] length_min = '0;
    logic [15:0] length_max = '0;
    logic        status_valid;
    logic        status_frame_pad;
    logic        status_frame_truncate;
    logic [15:0] status_frame_length;
    logic [15:0] status_orig_length;

    always #5 clk = ~clk;

    axis_frame_len_adjust #(
        .DATA_WIDTH(8),
        .USER_WIDTH(1),
        .LEN_WIDTH (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axis_tdata         (s_tdata),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_tlast         (s_tlast),
        .s_axis_tuser         (s_tuser),
        .m_axis_tdata         (m_tdata),
        .m_axis_tvalid        (m_tvalid),
        .m_axis_tready        (m_tready),
        .m_axis_tlast         (m_tlast),
        .m_axis_tuser         (m_tuser),
        .length_min           (length_min),
        .length_max           (length_max),
        .status_valid         (status_valid),
        .status_frame_pad     (status_frame_pad),
        .status_frame_truncate(status_frame_truncate),
        .status_frame_length  (status_frame_length),
        .status_orig_length   (status_orig_length)
    );

    typedef struct packed {logic [7:0] data; logic user; logic last;} beat_t;
    typedef struct packed {logic pad; logic trunc; logic [15:0] len; logic [15:0] orig;} stat_t;

    beat_t      exp_q[$];
    stat_t      stat_q[$];
    logic [7:0] fr_data[$];
    logic       fr_user[$];
    int         total = 0;
    int         bad = 0;
    bit         bp_en = 0;
    bit         gap_en = 0;
    stat_t      ms;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output of one whole frame, straight from the length rules.
    task automatic model_frame(input int mn, input int mx, output stat_t st);
        int    len;
        int    em;
        beat_t b;
        len = fr_data.size();
        em  = (mx != 0 && mn > mx) ? mx : mn;
        st  = '0;
        st.orig = 16'(len);
        if (mx != 0 && len > mx) begin
            for (int i = 0; i < mx; i++) begin
                b = '{data: fr_data[i], user: fr_user[i], last: (i == mx - 1)};
                exp_q.push_back(b);
            end
            st.trunc = 1'b1;
            st.len   = 16'(mx);
        end else begin
            for (int i = 0; i < len; i++) begin
                b = '{data: fr_data[i], user: fr_user[i], last: (i == len - 1) && (len >= em)};
                exp_q.push_back(b);
            end
            if (len < em) begin
                for (int i = len; i < em; i++) begin
                    b = '{data: 8'h00, user: fr_user[len-1], last: (i == em - 1)};
                    exp_q.push_back(b);
                end
                st.pad = 1'b1;
                st.len = 16'(em);
            end else begin
                st.len = 16'(len);
            end
        end
        stat_q.push_back(st);
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1.
    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        int waitc;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waitc    = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!s_tready && waitc < 300);
        if (!s_tready) chk("s_tready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int mn, input int mx, output stat_t st);
        length_min = 16'(mn);
        length_max = 16'(mx);
        model_frame(mn, mx, st);
        for (int i = 0; i < fr_data.size(); i++)
            send_beat(fr_data[i], fr_user[i], (i == fr_data.size() - 1));
    endtask

    task automatic set_frame_seq(input logic [7:0] start, input int len, input logic u);
        fr_data.delete();
        fr_user.delete();
        for (int i = 0; i < len; i++) begin
            fr_data.push_back(start + 8'(i));
            fr_user.push_back(u);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        chk("drain_left", 32'(exp_q.size() + stat_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output m_tready pattern, updated just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: every transfer and status pulse against the model, plus AXIS hold rule.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_user;
    always @(negedge clk) begin
        beat_t b;
        stat_t s;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(prev_data));
                chk("hold_last", 32'(m_tlast), 32'(prev_last));
                chk("hold_user", 32'(m_tuser), 32'(prev_user));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 32'(m_tdata), 32'(b.data));
                    chk("beat_last", 32'(m_tlast), 32'(b.last));
                    chk("beat_user", 32'(m_tuser), 32'(b.user));
                end
            end
            if (status_valid) begin
                if (stat_q.size() == 0) begin
                    chk("unexpected_status", 32'd1, 32'd0);
                end else begin
                    s = stat_q.pop_front();
                    chk("st_pad", 32'(status_frame_pad), 32'(s.pad));
                    chk("st_trunc", 32'(status_frame_truncate), 32'(s.trunc));
                    chk("st_len", 32'(status_frame_length), 32'(s.len));
                    chk("st_orig", 32'(status_orig_length), 32'(s.orig));
                end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            prev_user = m_tuser;
        end
    end

    initial begin
        int mn;
        int mx;
        int len;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_status_valid", 32'(status_valid), 32'd0);
        chk("rst_status_len", 32'(status_frame_length), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pad a 3-beat frame to 8.
        fr_data = '{8'hAA, 8'hBB, 8'hCC};
        fr_user = '{1'b1, 1'b0, 1'b1};
        send_frame(8, 0, ms);
        chk("model1_len", 32'(ms.len), 32'd8);
        chk("model1_orig", 32'(ms.orig), 32'd3);
        chk("model1_pad", 32'(ms.pad), 32'd1);
        wait_drain();
        chk("c1_pad", 32'(status_frame_pad), 32'd1);
        chk("c1_len", 32'(status_frame_length), 32'd8);
        chk("c1_orig", 32'(status_orig_length), 32'd3);

        // Truncate a 10-beat frame to 4.
        set_frame_seq(8'h01, 10, 1'b0);
        send_frame(0, 4, ms);
        chk("model2_trunc", 32'(ms.trunc), 32'd1);
        wait_drain();
        chk("c2_trunc", 32'(status_frame_truncate), 32'd1);
        chk("c2_len", 32'(status_frame_length), 32'd4);
        chk("c2_orig", 32'(status_orig_length), 32'd10);

        // Exactly min == max == length.
        set_frame_seq(8'h40, 4, 1'b1);
        send_frame(4, 4, ms);
        wait_drain();
        chk("c3_pad", 32'(status_frame_pad), 32'd0);
        chk("c3_trunc", 32'(status_frame_truncate), 32'd0);
        chk("c3_len", 32'(status_frame_length), 32'd4);

        // min above max: max wins as effective minimum.
        set_frame_seq(8'h70, 2, 1'b0);
        send_frame(10, 6, ms);
        wait_drain();
        chk("c5_pad", 32'(status_frame_pad), 32'd1);
        chk("c5_len", 32'(status_frame_length), 32'd6);
        chk("c5_orig", 32'(status_orig_length), 32'd2);

        // Single beat with min=1.
        set_frame_seq(8'h5A, 1, 1'b1);
        send_frame(1, 0, ms);
        wait_drain();
        chk("c1b_len", 32'(status_frame_length), 32'd1);

        // Back-to-back pad and truncate frames under random backpressure.
        bp_en = 1;
        fr_data = '{8'hAA, 8'hBB, 8'hCC};
        fr_user = '{1'b0, 1'b0, 1'b0};
        send_frame(8, 0, ms);
        set_frame_seq(8'h01, 10, 1'b1);
        send_frame(0, 4, ms);
        wait_drain();
        bp_en = 0;

        // Reset in the middle of padding.
        set_frame_seq(8'h90, 2, 1'b1);
        send_frame(20, 0, ms);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midpad_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midpad_s_tready", 32'(s_tready), 32'd0);
        chk("midpad_status_valid", 32'(status_valid), 32'd0);
        exp_q.delete();
        stat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_frame_seq(8'h20, 5, 1'b0);
        send_frame(3, 0, ms);
        wait_drain();
        chk("post_rst_len", 32'(status_frame_length), 32'd5);
        chk("post_rst_orig", 32'(status_orig_length), 32'd5);
        chk("post_rst_pad", 32'(status_frame_pad), 32'd0);

        // Randomized frames, back-to-back, with gaps and backpressure.
        bp_en  = 1;
        gap_en = 1;
        for (int f = 0; f < 60; f++) begin
            mn  = $urandom_range(0, 12);
            mx  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            len = $urandom_range(1, 16);
            fr_data.delete();
            fr_user.delete();
            for (int i = 0; i < len; i++) begin
                fr_data.push_back(8'($urandom));
                fr_user.push_back(1'($urandom));
            end
            send_frame(mn, mx, ms);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
